// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared types and helpers for the AXIS-to-SPI DAC transmitter
//
// Contents:
//   dac_state_e    : serializer FSM states (IDLE, SHIFT, QUIET)
//   FRAME_MAX      : widest frame the frame builder supports
//   bit_cnt_width  : width of the bit counter, $clog2(FRAME_BITS) (min 1)
//   div_cnt_width  : width of the sclk divider counter, $clog2(CLK_DIV+1)
//   build_frame    : places a DAC code inside a FRAME_BITS-wide word
package dac_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        QUIET = 2'd2
    } dac_state_e;

    localparam int FRAME_MAX = 64;

    function automatic int bit_cnt_width(input int frame_bits);
        return (frame_bits > 1) ? $clog2(frame_bits) : 1;
    endfunction

    function automatic int div_cnt_width(input int clk_div);
        return $clog2(clk_div + 1);
    endfunction

    // Frame layout, MSB first: lead zeros, code (dac_len bits), zero pad.
    // The result is right-aligned; callers keep the low frame_bits bits.
    function automatic logic [FRAME_MAX-1:0] build_frame(
        input logic [FRAME_MAX-1:0] code,
        input int                   dac_len,
        input int                   lead,
        input int                   frame_bits
    );
        logic [FRAME_MAX-1:0] mask;
        mask = {FRAME_MAX{1'b1}} >> (FRAME_MAX - dac_len);
        return (code & mask) << (frame_bits - lead - dac_len);
    endfunction

endpackage

// File: rtl/axis_dac_spi_tx_if.sv
// rtl/axis_dac_spi_tx_if.sv - AXI-Stream sample channel into the DAC transmitter
//
// Signals:
//   tdata  : sample word, DATA_W bits
//   tvalid : source has a sample
//   tready : transmitter can accept a sample
// Modports: master (sample source), slave (axis_dac_spi_tx).
interface axis_dac_spi_tx_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_code_fmt.sv
// rtl/dac_code_fmt.sv - combinational mapping of an AXIS sample to a DAC code
//
// Optional feature macro: AXIS_DAC_SIGNED_INPUT_EN
//   defined   : tdata is two's complement; saturate to the DAC range and
//               convert to offset binary
//   undefined : the low DAC_LENGTH bits are passed through unchanged
// Ports:
//   tdata : sample word from the stream, DATA_W bits
//   code  : unsigned DAC code, DAC_LENGTH bits
module dac_code_fmt #(
    parameter int DATA_W     = 32,
    parameter int DAC_LENGTH = 12
) (
    input  logic [DATA_W-1:0]     tdata,
    output logic [DAC_LENGTH-1:0] code
);

`ifdef AXIS_DAC_SIGNED_INPUT_EN
    localparam logic signed [63:0] MAX_V = (64'sd1 <<< (DAC_LENGTH - 1)) - 64'sd1;
    localparam logic signed [63:0] MIN_V = -(64'sd1 <<< (DAC_LENGTH - 1));

    logic signed [63:0] s_ext;

    always_comb begin
        s_ext = 64'($signed(tdata));
        if (s_ext > MAX_V) begin
            code = {DAC_LENGTH{1'b1}};
        end else if (s_ext < MIN_V) begin
            code = '0;
        end else begin
            // Adding 2^(DAC_LENGTH-1) modulo 2^DAC_LENGTH is an MSB flip.
            code = tdata[DAC_LENGTH-1:0] ^ {1'b1, {(DAC_LENGTH-1){1'b0}}};
        end
    end
`else
    // Upper tdata bits are deliberately ignored in unsigned mode.
    logic unused_tdata;
    assign unused_tdata = ^tdata;

    always_comb begin
        code = tdata[DAC_LENGTH-1:0];
    end
`endif

endmodule

// File: rtl/axis_dac_spi_tx.sv
// rtl/axis_dac_spi_tx.sv - AXI-Stream slave that shifts samples out to an SPI DAC
//
// Optional feature macro: AXIS_DAC_SIGNED_INPUT_EN (signed input, see dac_code_fmt).
// Ports:
//   CLK100MHz : system clock
//   ARESETN   : asynchronous active-low reset
//   s_axis    : sample stream (axis_dac_spi_tx_if.slave)
//   cs        : DAC chip select, active low
//   sclk      : serial clock, idles high, DAC samples on its falling edge
//   sdo       : serial data, MSB first
//   busy      : high from handshake until the quiet period ends
//   eoc_dac   : one-cycle pulse in the cycle cs returns high
module axis_dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int DAC_LENGTH   = 12,
    parameter int FRAME_BITS   = 16,
    parameter int LEAD_BITS    = 2,
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4,
    parameter int AXIS_BYTES   = 4
) (
    input  logic               CLK100MHz,
    input  logic               ARESETN,
    axis_dac_spi_tx_if.slave   s_axis,
    output logic               cs,
    output logic               sclk,
    output logic               sdo,
    output logic               busy,
    output logic               eoc_dac
);

    localparam int DATA_W    = AXIS_BYTES * 8;
    localparam int BIT_CNT_W = bit_cnt_width(FRAME_BITS);
    localparam int DIV_CNT_W = div_cnt_width(CLK_DIV);
    localparam int QUIET_W   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [DIV_CNT_W-1:0] LAST_DIV   = DIV_CNT_W'(CLK_DIV - 1);
    localparam logic [QUIET_W-1:0]   LAST_QUIET = QUIET_W'(QUIET_CYCLES - 1);

    dac_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [QUIET_W-1:0]    quiet_cnt_q, quiet_cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  sdo_q, sdo_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
    logic                  eoc_q, eoc_d;

    logic [DAC_LENGTH-1:0] code;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  handshake;

    dac_code_fmt #(
        .DATA_W     (DATA_W),
        .DAC_LENGTH (DAC_LENGTH)
    ) u_code_fmt (
        .tdata (s_axis.tdata),
        .code  (code)
    );

    assign frame_word = FRAME_BITS'(build_frame(FRAME_MAX'(code), DAC_LENGTH,
                                                LEAD_BITS, FRAME_BITS));

    // tready is registered, so the handshake never depends on tvalid
    // reaching an output in the same cycle.
    assign handshake = (state_q == IDLE) && tready_q && s_axis.tvalid;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        shreg_d     = shreg_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        sdo_d       = sdo_q;
        tready_d    = tready_q;
        busy_d      = busy_q;
        eoc_d       = 1'b0;

        case (state_q)
            IDLE: begin
                tready_d = 1'b1;
                busy_d   = 1'b0;
                cs_d     = 1'b1;
                sclk_d   = 1'b1;
                sdo_d    = 1'b0;
                if (handshake) begin
                    state_d   = SHIFT;
                    tready_d  = 1'b0;
                    busy_d    = 1'b1;
                    cs_d      = 1'b0;
                    sdo_d     = frame_word[FRAME_BITS-1];
                    shreg_d   = frame_word << 1;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end

            SHIFT: begin
                if (div_cnt_q == LAST_DIV) begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        // High phase over: falling edge, sdo held.
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        // Last low phase over: close the frame.
                        state_d     = QUIET;
                        cs_d        = 1'b1;
                        sclk_d      = 1'b1;
                        sdo_d       = 1'b0;
                        eoc_d       = 1'b1;
                        quiet_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sclk_d    = 1'b1;
                        sdo_d     = shreg_q[FRAME_BITS-1];
                        shreg_d   = shreg_q << 1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            QUIET: begin
                if (quiet_cnt_q == LAST_QUIET) begin
                    state_d  = IDLE;
                    tready_d = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                cs_d     = 1'b1;
                sclk_d   = 1'b1;
                sdo_d    = 1'b0;
                tready_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK100MHz or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            shreg_q     <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            sdo_q       <= 1'b0;
            tready_q    <= 1'b0;
            busy_q      <= 1'b0;
            eoc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            shreg_q     <= shreg_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            sdo_q       <= sdo_d;
            tready_q    <= tready_d;
            busy_q      <= busy_d;
            eoc_q       <= eoc_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign cs            = cs_q;
    assign sclk          = sclk_q;
    assign sdo           = sdo_q;
    assign busy          = busy_q;
    assign eoc_dac       = eoc_q;

endmodule

// File: tb/tb_axis_dac_spi_tx.sv
// tb/tb_axis_dac_spi_tx.sv - directed self-checking bench for axis_dac_spi_tx
module tb_axis_dac_spi_tx;

`ifdef AXIS_DAC_SIGNED_INPUT_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    axis_dac_spi_tx_if #(.DATA_W(32)) ifa ();
    axis_dac_spi_tx_if #(.DATA_W(32)) ifb ();

    wire [1:0] cs_o, sclk_o, sdo_o, busy_o, eoc_o, hs;
    assign hs[0] = ifa.tvalid & ifa.tready;
    assign hs[1] = ifb.tvalid & ifb.tready;

    axis_dac_spi_tx dut_a (
        .CLK100MHz (clk), .ARESETN (rstn), .s_axis (ifa),
        .cs (cs_o[0]), .sclk (sclk_o[0]), .sdo (sdo_o[0]),
        .busy (busy_o[0]), .eoc_dac (eoc_o[0])
    );

    axis_dac_spi_tx #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut_b (
        .CLK100MHz (clk), .ARESETN (rstn), .s_axis (ifb),
        .cs (cs_o[1]), .sclk (sclk_o[1]), .sdo (sdo_o[1]),
        .busy (busy_o[1]), .eoc_dac (eoc_o[1])
    );

    // Per-DUT frame monitor: collects sdo at every falling sclk while cs is low.
    for (genvar g = 0; g < 2; g++) begin : mon
        logic [15:0] acc   = '0;
        int          nb    = 0;
        int          run   = 0;
        int          falls = 0;
        int          eocs  = 0;
        logic        pcs   = 1'b1;
        logic        psclk = 1'b1;
        logic [15:0] fq[$];
        int          lq[$];
        int          nq[$];
        int          hq[$];
        logic        eq[$];

        always @(negedge clk) begin
            if (!rstn) begin
                acc = '0;
                nb  = 0;
                run = 0;
            end else begin
                if (psclk && !sclk_o[g] && !cs_o[g]) begin
                    acc = {acc[14:0], sdo_o[g]};
                    nb++;
                end
                if (!cs_o[g]) begin
                    run++;
                end else if (!pcs) begin
                    fq.push_back(acc);
                    lq.push_back(run);
                    nq.push_back(nb);
                    eq.push_back(eoc_o[g]);
                    acc = '0;
                    nb  = 0;
                    run = 0;
                end
                if (eoc_o[g]) eocs++;
                if (hs[g]) hq.push_back(cyc);
            end
            if (psclk && !sclk_o[g]) falls++;
            pcs   = cs_o[g];
            psclk = sclk_o[g];
        end
    end

    function automatic logic [15:0] ef(input logic [15:0] u, input logic [15:0] s);
        return SGN ? s : u;
    endfunction

    function automatic int fcount(input int g);
        return (g == 0) ? mon[0].fq.size() : mon[1].fq.size();
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int g, input logic [31:0] d);
        int k;
        k = 0;
        if (g == 0) begin ifa.tdata = d; ifa.tvalid = 1'b1; end
        else        begin ifb.tdata = d; ifb.tvalid = 1'b1; end
        @(negedge clk);
        while (!((g == 0) ? ifa.tready : ifb.tready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("handshake_timeout", longint'(k < 300), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_frames(input int g, input int n);
        int k;
        k = 0;
        while (fcount(g) < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("frame_timeout", longint'(fcount(g) >= n), 1);
    endtask

    task automatic wait_ready_a();
        int k;
        k = 0;
        while (!ifa.tready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_timeout", longint'(ifa.tready), 1);
    endtask

    initial begin
        int k, base, hb, f0;
        ifa.tvalid = 1'b0; ifa.tdata = '0;
        ifb.tvalid = 1'b0; ifb.tdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs",     cs_o[0],    1);
        chk("rst_sclk",   sclk_o[0],  1);
        chk("rst_sdo",    sdo_o[0],   0);
        chk("rst_busy",   busy_o[0],  0);
        chk("rst_eoc",    eoc_o[0],   0);
        chk("rst_tready", ifa.tready, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_tready_a", ifa.tready, 1);
        chk("rel_tready_b", ifb.tready, 1);

        // Single beat 0xABC
        base = mon[0].fq.size();
        send(0, 32'h0000_0ABC);
        ifa.tvalid = 1'b0;
        chk("t1_tready_lo", ifa.tready, 0);
        chk("t1_busy_hi",   busy_o[0],  1);
        chk("t1_cs_lo",     cs_o[0],    0);
        chk("t1_sclk_hi",   sclk_o[0],  1);
        k = 0;
        while (!cs_o[0] && k < 200) begin @(posedge clk); #1; k++; end
        chk("t1_eoc_at_cs_rise", eoc_o[0], 1);
        chk("t1_sdo_end",        sdo_o[0], 0);
        k = 0;
        while (!ifa.tready && k < 20) begin @(posedge clk); #1; k++; end
        chk("t1_quiet_cycles", k, 4);
        chk("t1_busy_lo",      busy_o[0], 0);
        chk("t1_frame",  mon[0].fq[base], ef(16'h2AF0, 16'h3FFC));
        chk("t1_cs_len", mon[0].lq[base], 64);
        chk("t1_nbits",  mon[0].nq[base], 16);
        chk("t1_eocs",   mon[0].eocs,     1);

        // Back-to-back stream with tvalid held
        base = mon[0].fq.size();
        hb   = mon[0].hq.size();
        send(0, 32'h0000_0000);
        send(0, 32'h0000_0FFF);
        send(0, 32'h0000_0555);
        ifa.tvalid = 1'b0;
        wait_frames(0, base + 3);
        chk("t2_gap1",   mon[0].hq[hb+1] - mon[0].hq[hb],   69);
        chk("t2_gap2",   mon[0].hq[hb+2] - mon[0].hq[hb+1], 69);
        chk("t2_frame0", mon[0].fq[base],   ef(16'h0000, 16'h2000));
        chk("t2_frame1", mon[0].fq[base+1], ef(16'h3FFC, 16'h3FFC));
        chk("t2_frame2", mon[0].fq[base+2], ef(16'h1554, 16'h3554));
        chk("t2_eoc0",   mon[0].eq[base+2], 1);

        // tvalid pulses while busy
        wait_ready_a();
        base = mon[0].fq.size();
        hb   = mon[0].hq.size();
        send(0, 32'h0000_0123);
        ifa.tvalid = 1'b0;
        ifa.tdata  = 32'h0000_09A5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; ifa.tvalid = 1'b1;
            @(posedge clk); #1; ifa.tvalid = 1'b0;
        end
        chk("t3_tready_lo", ifa.tready, 0);
        chk("t3_no_hs",     mon[0].hq.size() - hb, 1);
        send(0, 32'h0000_09A5);
        ifa.tvalid = 1'b0;
        chk("t3_gap", mon[0].hq[hb+1] - mon[0].hq[hb], 69);
        wait_frames(0, base + 2);
        chk("t3_frame0", mon[0].fq[base],   ef(16'h048C, 16'h248C));
        chk("t3_frame1", mon[0].fq[base+1], ef(16'h2694, 16'h3FFC));

        // Asynchronous reset in the low phase of bit 7
        wait_ready_a();
        base = mon[0].fq.size();
        send(0, 32'h0000_0C3A);
        ifa.tvalid = 1'b0;
        k = 0;
        while (mon[0].nb < 8 && k < 200) begin @(posedge clk); #1; k++; end
        chk("t4_bit7_reached", mon[0].nb, 8);
        f0 = mon[0].falls;
        #2;
        rstn = 1'b0;
        #1;
        chk("t4_cs",     cs_o[0],    1);
        chk("t4_sclk",   sclk_o[0],  1);
        chk("t4_sdo",    sdo_o[0],   0);
        chk("t4_busy",   busy_o[0],  0);
        chk("t4_tready", ifa.tready, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("t4_tready_rel", ifa.tready, 0);
        @(posedge clk); #1;
        chk("t4_tready_edge", ifa.tready, 1);
        chk("t4_no_fall",     mon[0].falls - f0, 0);
        chk("t4_no_partial",  mon[0].fq.size() - base, 0);
        send(0, 32'hFFFF_F5A3);
        ifa.tvalid = 1'b0;
        wait_frames(0, base + 1);
        chk("t4_frame",  mon[0].fq[base], ef(16'h168C, 16'h0000));
        chk("t4_cs_len", mon[0].lq[base], 64);

`ifdef AXIS_DAC_SIGNED_INPUT_EN
        // Signed saturation and offset-binary conversion
        wait_ready_a();
        base = mon[0].fq.size();
        send(0, 32'hFFFF_F800);
        send(0, 32'h0000_0000);
        send(0, 32'h0000_1000);
        send(0, 32'hFFFF_0000);
        ifa.tvalid = 1'b0;
        wait_frames(0, base + 4);
        chk("s_min",     mon[0].fq[base],   16'h0000);
        chk("s_zero",    mon[0].fq[base+1], 16'h2000);
        chk("s_sat_hi",  mon[0].fq[base+2], 16'h3FFC);
        chk("s_sat_lo",  mon[0].fq[base+3], 16'h0000);
`endif

        // CLK_DIV=1, QUIET_CYCLES=1 instance
        base = mon[1].fq.size();
        hb   = mon[1].hq.size();
        send(1, 32'h0000_00F0);
        send(1, 32'h0000_0F0F);
        ifb.tvalid = 1'b0;
        wait_frames(1, base + 2);
        chk("b_gap",    mon[1].hq[hb+1] - mon[1].hq[hb], 34);
        chk("b_cs_len", mon[1].lq[base], 32);
        chk("b_nbits",  mon[1].nq[base], 16);
        chk("b_frame0", mon[1].fq[base],   ef(16'h03C0, 16'h23C0));
        chk("b_frame1", mon[1].fq[base+1], ef(16'h3C3C, 16'h3FFC));
        chk("b_eoc",    mon[1].eq[base+1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_dac_spi_tx.md
Name: axis_dac_spi_tx

Overview:
AXI-Stream slave to serial-DAC transmitter. It is the output-side counterpart of the AD7276 capture path, which reads cs/sclk/SDATA frames and converts them to AXIS. This block takes one AXIS sample per beat, formats it into a FRAME_BITS-wide word and shifts it MSB-first to an SPI DAC over cs/sclk/sdo. It sits between the control/processing fabric and the board DAC connector, and its frame layout matches the ADC side (leading zeros, data, trailing zeros).

Parameters:
DAC_LENGTH, 12, DAC resolution in bits.
FRAME_BITS, 16, sclk periods per cs-low frame.
LEAD_BITS, 2, zero bits sent before the data MSB. Constraint: LEAD_BITS+DAC_LENGTH <= FRAME_BITS.
CLK_DIV, 2, CLK100MHz cycles per sclk half-period. Must be >= 1.
QUIET_CYCLES, 4, minimum cycles cs stays high between frames. Must be >= 1.
AXIS_BYTES, 4, s_axis_tdata width in bytes. Constraint: AXIS_BYTES*8 >= DAC_LENGTH.

Ports:
CLK100MHz  in  1  system clock.
ARESETN  in  1  asynchronous active-low reset.
s_axis_tdata  in  AXIS_BYTES*8  sample; unsigned code in bits [DAC_LENGTH-1:0].
s_axis_tvalid  in  1  sample valid.
s_axis_tready  out  1  block can accept a sample.
cs  out  1  DAC chip select, active low.
sclk  out  1  serial clock; idles high.
sdo  out  1  serial data to the DAC.
busy  out  1  high from handshake until the end of the quiet period.
eoc_dac  out  1  one-cycle pulse when cs rises at the end of a frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - cs=1, sclk=1, sdo=0, busy=0, eoc_dac=0, s_axis_tready=0.
  - State IDLE; counters and shift register cleared. A partial frame is aborted and never resumed.
  - The first rising edge after ARESETN deasserts sets s_axis_tready=1.
- FSM states: IDLE, SHIFT, QUIET.
- IDLE:
  - s_axis_tready=1 and busy=0.
  - On tvalid&tready at edge N: capture the frame word and go to SHIFT.
  - Frame word = LEAD_BITS zeros, then tdata[DAC_LENGTH-1:0], then zero pad to FRAME_BITS.
  - tdata bits above DAC_LENGTH are ignored.
- SHIFT:
  - From edge N, register s_axis_tready=0 and busy=1; cs=0 is visible in cycle N+1.
  - Each bit occupies 2*CLK_DIV cycles: CLK_DIV cycles with sclk=1 and sdo=current bit, then CLK_DIV cycles with sclk=0 and sdo held. The DAC samples on the falling sclk edge.
  - A bit counter counts 0..FRAME_BITS-1. When the last low phase ends, sclk returns to 1 and cs to 1 on the same edge, eoc_dac=1 for exactly that cycle, and sdo=0.
  - cs is low for exactly FRAME_BITS*2*CLK_DIV cycles.
- QUIET:
  - cs=1, sclk=1, s_axis_tready=0 for QUIET_CYCLES cycles, then IDLE.
  - Sustained throughput is one sample per 1+FRAME_BITS*2*CLK_DIV+QUIET_CYCLES cycles (69 with defaults).
- tvalid asserted while busy: no handshake occurs. The upstream beat is held per AXIS rules and is not dropped or overwritten.
- tvalid is sampled only in IDLE. A tvalid that rises in the same cycle IDLE is re-entered is accepted in that cycle.
- All outputs are registered; no combinational path from s_axis_tvalid to any output.

Optional Feature:
Macro: AXIS_DAC_SIGNED_INPUT_EN.
- Defined: s_axis_tdata is two's-complement, AXIS_BYTES*8 wide.
  - Saturate to [-2^(DAC_LENGTH-1), 2^(DAC_LENGTH-1)-1].
  - Add 2^(DAC_LENGTH-1) to get offset binary.
  - Conversion is registered at the handshake; latency is unchanged.
- Undefined: no saturation; the low DAC_LENGTH bits are sent unchanged as an unsigned code.

Decomposition:
- Package dac_spi_pkg holds:
  - the state enum (IDLE, SHIFT, QUIET);
  - a function that builds the frame word from the code, LEAD_BITS and FRAME_BITS;
  - localparam widths for the bit counter ($clog2(FRAME_BITS)) and divider counter ($clog2(CLK_DIV+1)).
- One sub-module, dac_code_fmt: a purely combinational tdata-to-code mapper, containing the AXIS_DAC_SIGNED_INPUT_EN saturation/offset logic. Serializer, FSM and handshake stay in axis_dac_spi_tx.

Test Plan:
- Single beat, defaults, tdata=0x00000ABC: sdo at the 16 falling edges = 0010101011110000; cs low 64 cycles; one eoc_dac pulse; tready back to 1 after 4 quiet cycles.
- tvalid held high with a stream of 0x000, 0xFFF, 0x555: handshakes exactly 69 cycles apart; every word is sent intact and in order.
- tvalid pulses during SHIFT/QUIET with tdata held: tready stays 0 and no handshake occurs; the beat is accepted on the first IDLE cycle and sent correctly.
- ARESETN low during bit 7: cs=1, sclk=1, sdo=0 immediately, with no extra falling edge. After release, tready=1 one edge later and the next frame is complete and correct.
- CLK_DIV=1, QUIET_CYCLES=1: sclk toggles every cycle; cs low 32 cycles; throughput one sample per 34 cycles.
- AXIS_DAC_SIGNED_INPUT_EN defined:
  - tdata=0xFFFFF800 → code 0x000;
  - 0x00000000 → 0x800;
  - 0x00001000 → 0xFFF (saturated);
  - 0xFFFF0000 → 0x000 (saturated).
